// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer control and status bundle. The front-end controller drives it as master.
// The sequencer is the slave.
interface pc_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  stall;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  exc_valid;
  logic [1:0]            exc_code;
  logic                  call_valid;
  logic [DATA_WIDTH-1:0] call_target;
  logic                  ret_valid;
  logic [DATA_WIDTH-1:0] current_pc;
  logic                  ras_empty;
  logic                  ras_full;
  logic                  ret_miss;
  logic                  align_fault;

  modport master (
    output stall, redirect_valid, redirect_target, exc_valid, exc_code,
           call_valid, call_target, ret_valid,
    input  current_pc, ras_empty, ras_full, ret_miss, align_fault
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, exc_valid, exc_code,
           call_valid, call_target, ret_valid,
    output current_pc, ras_empty, ras_full, ret_miss, align_fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Prioritised fetch-PC generator with a circular return-address stack.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect/call targets instead of masking their low bits.
module pc_sequencer #(
  parameter int unsigned                DATA_WIDTH   = 64,
  parameter logic [DATA_WIDTH-1:0]      RESET_VECTOR = '0,
  parameter int unsigned                INST_BYTES   = 4,
  parameter logic [DATA_WIDTH-1:0]      EXC_BASE     = 'h400,
  parameter int unsigned                RAS_DEPTH    = 8
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [DATA_WIDTH-1:0] addr_t;

  localparam addr_t ALIGN_MASK = addr_t'(INST_BYTES - 1);
  localparam addr_t ALIGN_VEC  = EXC_BASE + addr_t'(12'h180);

  addr_t            pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retMiss_q, retMiss_d;
  logic             alignFault_q, alignFault_d;

  addr_t            ras_q [RAS_DEPTH];
  logic             rasWe;
  logic [PTR_W-1:0] rasWaddr;

  addr_t            seqPc, excVec, redirTarget, callTarget;
  logic             redirBad, callBad, rasEmpty, rasFull;
  logic [PTR_W-1:0] topIdx;

  assign seqPc    = pc_q + addr_t'(INST_BYTES);
  assign excVec   = EXC_BASE + (addr_t'(bus.exc_code) << 7);
  assign topIdx   = ptr_q - PTR_W'(1);
  assign rasEmpty = (cnt_q == '0);
  assign rasFull  = (cnt_q == CNT_W'(RAS_DEPTH));

`ifdef PC_ALIGN_CHECK_EN
  assign redirTarget = bus.redirect_target;
  assign callTarget  = bus.call_target;
  assign redirBad    = |(bus.redirect_target & ALIGN_MASK);
  assign callBad     = |(bus.call_target & ALIGN_MASK);
`else
  assign redirTarget = bus.redirect_target & ~ALIGN_MASK;
  assign callTarget  = bus.call_target & ~ALIGN_MASK;
  assign redirBad    = 1'b0;
  assign callBad     = 1'b0;
`endif

  // ptr_q is the next free slot, so a push while full lands on the oldest entry.
  always_comb begin
    pc_d         = seqPc;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    retMiss_d    = 1'b0;
    alignFault_d = 1'b0;
    rasWe        = 1'b0;
    rasWaddr     = ptr_q;

    if (bus.exc_valid) begin
      pc_d  = excVec;
      cnt_d = '0;
      ptr_d = '0;
    end else if (bus.redirect_valid) begin
      if (redirBad) begin
        pc_d         = ALIGN_VEC;
        cnt_d        = '0;
        ptr_d        = '0;
        alignFault_d = 1'b1;
      end else begin
        pc_d = redirTarget;
      end
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.call_valid) begin
      if (callBad) begin
        pc_d         = ALIGN_VEC;
        cnt_d        = '0;
        ptr_d        = '0;
        alignFault_d = 1'b1;
      end else begin
        pc_d  = callTarget;
        rasWe = 1'b1;
        if (bus.ret_valid && !rasEmpty) begin
          rasWaddr = topIdx;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
          if (!rasFull) cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (bus.ret_valid) begin
      if (!rasEmpty) begin
        pc_d  = ras_q[topIdx];
        ptr_d = topIdx;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        retMiss_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      ptr_q        <= '0;
      cnt_q        <= '0;
      retMiss_q    <= 1'b0;
      alignFault_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      retMiss_q    <= retMiss_d;
      alignFault_q <= alignFault_d;
    end
  end

  // Stack contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk) begin
    if (rasWe && !reset) ras_q[rasWaddr] <= seqPc;
  end

  assign bus.current_pc  = pc_q;
  assign bus.ras_empty   = rasEmpty;
  assign bus.ras_full    = rasFull;
  assign bus.ret_miss    = retMiss_q;
  assign bus.align_fault = alignFault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them one cycle after each stimulus is applied.
module tb_pc_sequencer;
  localparam int unsigned DW = 64;
  typedef logic [DW-1:0] addr_t;

  // Flag order: {ras_empty, ras_full, ret_miss, align_fault}
  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_EMPTY = 4'b1000;
  localparam logic [3:0] F_FULL  = 4'b0100;
  localparam logic [3:0] F_MISS  = 4'b1010;
  localparam logic [3:0] F_ALIGN = 4'b1001;

  typedef struct {
    int unsigned cyc;
    string       name;
    addr_t       pc;
    logic [3:0]  flags;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  exp_t        expQ[$];
  int unsigned cycCount = 0;
  int          errors = 0;
  int          checks = 0;

  pc_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  pc_sequencer #(
    .DATA_WIDTH  (DW),
    .RESET_VECTOR('0),
    .INST_BYTES  (4),
    .EXC_BASE    (64'h400),
    .RAS_DEPTH   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  task automatic checkOutput(input exp_t e);
    logic [3:0] got;
    got = {bus.ras_empty, bus.ras_full, bus.ret_miss, bus.align_fault};
    checks++;
    if (bus.current_pc !== e.pc || got !== e.flags) begin
      errors++;
      $display("[TB] FAIL %s: pc got %h want %h, flags{empty,full,miss,align} got %b want %b",
               e.name, bus.current_pc, e.pc, got, e.flags);
    end
  endtask

  // Monitor: each expectation becomes due one cycle after its stimulus.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (expQ.size() > 0 && expQ[0].cyc < cycCount) begin
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cycCount);
    end
    if (expQ.size() > 0 && expQ[0].cyc == cycCount) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic applyStimulus(input string nm, input logic rst, input logic stl,
                               input logic rv, input addr_t rt, input logic ev, input logic [1:0] ec,
                               input logic cv, input addr_t ct, input logic retv,
                               input addr_t ePc, input logic [3:0] eFlags);
    exp_t e;
    @(posedge clk);
    #1;
    reset               = rst;
    bus.stall           = stl;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.exc_valid       = ev;
    bus.exc_code        = ec;
    bus.call_valid      = cv;
    bus.call_target     = ct;
    bus.ret_valid       = retv;
    e.cyc   = cycCount + 1;
    e.name  = nm;
    e.pc    = ePc;
    e.flags = eFlags;
    expQ.push_back(e);
  endtask

  task automatic doFree(input string nm, input addr_t ePc, input logic [3:0] f);
    applyStimulus(nm, 0, 0, 0, '0, 0, 2'd0, 0, '0, 0, ePc, f);
  endtask

  task automatic doCall(input string nm, input addr_t t, input addr_t ePc, input logic [3:0] f);
    applyStimulus(nm, 0, 0, 0, '0, 0, 2'd0, 1, t, 0, ePc, f);
  endtask

  task automatic doRet(input string nm, input addr_t ePc, input logic [3:0] f);
    applyStimulus(nm, 0, 0, 0, '0, 0, 2'd0, 0, '0, 1, ePc, f);
  endtask

  task automatic doRedirect(input string nm, input addr_t t, input addr_t ePc, input logic [3:0] f);
    applyStimulus(nm, 0, 0, 1, t, 0, 2'd0, 0, '0, 0, ePc, f);
  endtask

  initial begin
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.exc_valid       = 1'b0;
    bus.exc_code        = 2'd0;
    bus.call_valid      = 1'b0;
    bus.call_target     = '0;
    bus.ret_valid       = 1'b0;

    applyStimulus("reset0", 1, 0, 0, '0, 0, 2'd0, 0, '0, 0, 64'h0, F_EMPTY);
    applyStimulus("reset1", 1, 0, 0, '0, 0, 2'd0, 1, 64'h77, 1, 64'h0, F_EMPTY);
    doFree("seq4", 64'h4, F_EMPTY);
    doFree("seq8", 64'h8, F_EMPTY);
    doFree("seqC", 64'hC, F_EMPTY);
    doFree("seq10", 64'h10, F_EMPTY);

    doCall("call100", 64'h100, 64'h100, F_NONE);
    doRet("ret14", 64'h14, F_EMPTY);

    for (int k = 1; k <= 9; k++)
      doCall($sformatf("nest_call%0d", k), addr_t'(k) * 64'h1000, addr_t'(k) * 64'h1000,
             (k >= 8) ? F_FULL : F_NONE);
    for (int j = 1; j <= 8; j++)
      doRet($sformatf("nest_ret%0d", j), addr_t'(9 - j) * 64'h1000 + 64'h4,
            (j == 8) ? F_EMPTY : F_NONE);
    doRet("ret_miss", 64'h1008, F_MISS);
    doFree("miss_clear", 64'h100C, F_EMPTY);

    doRedirect("redir50", 64'h50, 64'h50, F_EMPTY);
    doCall("call1C", 64'h1C, 64'h1C, F_NONE);
    doFree("seq20", 64'h20, F_NONE);
    applyStimulus("stall_call_a", 0, 1, 0, '0, 0, 2'd0, 1, 64'h999, 0, 64'h20, F_NONE);
    applyStimulus("stall_call_b", 0, 1, 0, '0, 0, 2'd0, 1, 64'h999, 0, 64'h20, F_NONE);
    applyStimulus("stall_redir300", 0, 1, 1, 64'h300, 0, 2'd0, 1, 64'h999, 0, 64'h300, F_NONE);
    doRet("ret54", 64'h54, F_EMPTY);

    doCall("call600", 64'h600, 64'h600, F_NONE);
    applyStimulus("tail700", 0, 0, 0, '0, 0, 2'd0, 1, 64'h700, 1, 64'h700, F_NONE);
    doRet("ret604", 64'h604, F_EMPTY);
    applyStimulus("tail_empty800", 0, 0, 0, '0, 0, 2'd0, 1, 64'h800, 1, 64'h800, F_NONE);

    applyStimulus("exc2_redir", 0, 0, 1, 64'h123, 1, 2'd2, 0, '0, 0, 64'h500, F_EMPTY);
    doRet("ret_after_flush", 64'h504, F_MISS);
    applyStimulus("stall_ret", 0, 1, 0, '0, 0, 2'd0, 0, '0, 1, 64'h504, F_EMPTY);

`ifdef PC_ALIGN_CHECK_EN
    doRedirect("redir_misalign", 64'h202, 64'h580, F_ALIGN);
    doFree("align_pulse_end", 64'h584, F_EMPTY);
    doCall("call_misalign", 64'h30A, 64'h580, F_ALIGN);
    doRet("ret_no_push", 64'h584, F_MISS);
`else
    doRedirect("redir_misalign", 64'h202, 64'h200, F_EMPTY);
    doFree("align_pulse_end", 64'h204, F_EMPTY);
    doCall("call_misalign", 64'h30A, 64'h308, F_NONE);
    doRet("ret_pushed", 64'h208, F_EMPTY);
`endif

    doRedirect("redir_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_EMPTY);
    doFree("wrap0", 64'h0, F_EMPTY);
    applyStimulus("exc0", 0, 1, 0, '0, 1, 2'd0, 0, '0, 0, 64'h400, F_EMPTY);
    applyStimulus("exc3", 0, 0, 0, '0, 1, 2'd3, 0, '0, 0, 64'h580, F_EMPTY);

    doCall("call_pre_reset", 64'hA00, 64'hA00, F_NONE);
    applyStimulus("reset_mid", 1, 0, 1, 64'h40, 1, 2'd1, 1, 64'h88, 0, 64'h0, F_EMPTY);
    doFree("post_reset", 64'h4, F_EMPTY);
    doRet("post_reset_ret", 64'h8, F_MISS);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised fetch-PC generator for the CPU front end. It replaces the plain reset/load PC register with a prioritised next-PC selector covering sequential increment, stall, branch redirect, exception vectoring, and call/return prediction through an internal return-address stack (RAS). Its output drives the instruction-memory address and the IF/ID pipeline register.

Parameters:
DATA_WIDTH, 64, width of PC and all address ports
RESET_VECTOR, 0, PC value loaded on reset
INST_BYTES, 4, sequential increment in bytes
EXC_BASE, 'h400, base address of the exception vector table
RAS_DEPTH, 8, number of RAS entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and RAS this cycle
redirect_valid  input  1  branch resolved mispredicted/taken from EX
redirect_target  input  DATA_WIDTH  redirect destination
exc_valid  input  1  exception taken
exc_code  input  2  vector index, 0..3
call_valid  input  1  fetch decoded a BL/BLR at current_pc
call_target  input  DATA_WIDTH  call destination
ret_valid  input  1  fetch decoded a RET at current_pc
current_pc  output  DATA_WIDTH  registered fetch PC
ras_empty  output  1  RAS count == 0
ras_full  output  1  RAS count == RAS_DEPTH
ret_miss  output  1  registered one-cycle pulse: RET with empty RAS
align_fault  output  1  registered one-cycle pulse, see Optional Feature

Behaviour:
- Reset: current_pc=RESET_VECTOR, RAS count=0, top pointer=0, ret_miss=0, align_fault=0. Reset overrides every other input in the same cycle; reset asserted mid-operation discards all in-flight state.
- Next-PC priority, highest first: reset > exc_valid > redirect_valid > stall > ret_valid/call_valid > sequential.
- exc_valid: next = EXC_BASE + exc_code*'h80; RAS flushed (count=0); stall ignored.
- redirect_valid: next = redirect_target; RAS unchanged; stall ignored.
- stall (no exc/redirect): current_pc and RAS hold; call/ret ignored; ret_miss=0.
- Sequential: next = current_pc + INST_BYTES, truncated to DATA_WIDTH (wraps to 0 at top of address space).
- call_valid only: push current_pc+INST_BYTES, next = call_target. Push when full: circular overwrite of oldest entry, count stays RAS_DEPTH.
- ret_valid only: count>0 -> next = top entry, pop. Count==0 -> next = sequential, ret_miss=1 next cycle.
- call_valid and ret_valid together (tail call): top entry replaced by current_pc+INST_BYTES, count unchanged (if empty, acts as push), next = call_target.
- Latency: each PC update takes one clock; current_pc is a pure register output, with no combinational path from inputs.
- RAS storage is written only on push/replace; no reset is needed on storage, only on pointer/count.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: if a selected redirect_target or call_target has nonzero bits [log2(INST_BYTES)-1:0], next = EXC_BASE + 'h180 (code 3), RAS flushed, align_fault=1 for one cycle; the push for a misaligned call is suppressed.
- Undefined: those low bits are forced to zero on load, align_fault tied 0.

Test Plan:
- Reset then 3 free cycles -> current_pc 0, 4, 8, 'hC; ras_empty=1.
- At pc='h10 call_valid, call_target='h100; next cycle ret_valid -> pc='h100, then 'h14; RAS count back to 0.
- 9 nested calls with RAS_DEPTH=8 -> ras_full=1; 9 rets return the 8 newest return addresses, 9th gives ret_miss=1 and sequential pc.
- stall with call_valid at pc='h20 for 2 cycles -> pc holds 'h20, RAS unchanged; simultaneous redirect_valid target='h300 -> pc='h300 despite stall.
- exc_valid code 2 together with redirect_valid -> pc=EXC_BASE+'h100='h500, RAS empty.
- PC_ALIGN_CHECK_EN: redirect_target='h202 -> pc='h580, align_fault pulse; without macro -> pc='h200, align_fault=0.
